// File: rtl/load_store_pkg.sv
// Shared types for the load path: funct3 encodings, load control word, FSM states.
package load_store_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned LANE_W = 2;
  localparam int unsigned RD_W   = 5;

  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } l_state_t;

  // Load control: funct3 plus the byte lane, laid out like the store control word.
  typedef struct packed {
    logic [F3_W-1:0]   funct3;
    logic [LANE_W-1:0] lane;
  } l_ctrl_t;

  // High for an illegal funct3 or a misaligned half/word access.
  function automatic logic ctrl_err(input l_ctrl_t c);
    case (c.funct3)
      F3_LB, F3_LBU: return 1'b0;
      F3_LH, F3_LHU: return c.lane[0];
      F3_LW:         return c.lane != LANE_W'(0);
      default:       return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_unit_if.sv
// Load unit bus bundle: request, data-memory read and writeback channels.
// Modports: slave = load unit, master = core/memory side driving it.
interface load_unit_if;
  import load_store_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [F3_W-1:0]     req_funct3;
  logic [XLEN-1:0]     req_addr;
  logic [RD_W-1:0]     req_rd;

  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [XLEN-1:0]     mem_addr;
  logic                mem_rvalid;
  logic [XLEN-1:0]     mem_rdata;

  logic                wb_valid;
  logic                wb_ready;
  logic [XLEN-1:0]     wb_data;
  logic [RD_W-1:0]     wb_rd;
  logic                wb_err;

  modport slave (
    input  req_valid, req_funct3, req_addr, req_rd,
    input  mem_req_ready, mem_rvalid, mem_rdata,
    input  wb_ready,
    output req_ready, mem_req_valid, mem_addr,
    output wb_valid, wb_data, wb_rd, wb_err
  );

  modport master (
    output req_valid, req_funct3, req_addr, req_rd,
    output mem_req_ready, mem_rvalid, mem_rdata,
    output wb_ready,
    input  req_ready, mem_req_valid, mem_addr,
    input  wb_valid, wb_data, wb_rd, wb_err
  );

endinterface

// File: rtl/load_extract.sv
// Combinational byte/half/word selection with sign or zero extension.
// Ports: funct3 (load type), lane (addr[1:0]), rdata (read word), data_c (result).
module load_extract
  import load_store_pkg::*;
(
  input  logic [F3_W-1:0]   funct3,
  input  logic [LANE_W-1:0] lane,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (lane)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

    data_c = '0;
    case (funct3)
      F3_LB:   data_c = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data_c = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   data_c = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  data_c = {{(XLEN-16){1'b0}}, half_sel};
      F3_LW:   data_c = rdata;
      default: data_c = '0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Sequential load path: checks alignment, issues a word read, extracts and
// extends the addressed data, returns it through a valid/ready writeback port.
// Ports: clk, rst_n (async active-low), bus (load_unit_if.slave: req/mem/wb).
// Optional LOAD_TIMEOUT_EN: WAIT aborts with wb_err after TIMEOUT_CYCLES and
// the orphaned read response is later dropped.
module load_unit
  import load_store_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TMO_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  load_unit_if.slave bus
);

  l_state_t        state, state_n;
  l_ctrl_t         ctrl_in, ctrl_q;
  logic            accept, req_err, data_done, tmo_fire;
  logic            rsp_take, tmo_hit;
  logic [XLEN-1:0] ext_data_c;

  load_extract u_extract (
    .funct3 (ctrl_q.funct3),
    .lane   (ctrl_q.lane),
    .rdata  (bus.mem_rdata),
    .data_c (ext_data_c)
  );

`ifdef LOAD_TIMEOUT_EN
  logic             stale_q;
  logic [TMO_W-1:0] tmo_cnt;

  // A response owed to a timed-out load must not complete a later one.
  assign rsp_take = bus.mem_rvalid && !stale_q;
  assign tmo_hit  = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Timeout counter and stale-response flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      stale_q <= 1'b0;
    end else begin
      if (state_n == S_WAIT && state != S_WAIT) begin
        tmo_cnt <= '0;
      end else if (state == S_WAIT && !rsp_take) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
      if (tmo_fire) begin
        stale_q <= 1'b1;
      end else if (bus.mem_rvalid && stale_q) begin
        stale_q <= 1'b0;
      end
    end
  end
`else
  logic tmo_unused;

  assign rsp_take   = bus.mem_rvalid;
  assign tmo_hit    = 1'b0;
  assign tmo_unused = |TMO_W'(TIMEOUT_CYCLES);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state and transition strobes.
  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    req_err   = 1'b0;
    data_done = 1'b0;
    tmo_fire  = 1'b0;
    ctrl_in   = '{funct3: bus.req_funct3, lane: bus.req_addr[LANE_W-1:0]};
    case (state)
      S_IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          accept  = 1'b1;
          req_err = ctrl_err(ctrl_in);
          state_n = req_err ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        if (bus.mem_req_ready) state_n = S_WAIT;
      end
      S_WAIT: begin
        // Data beats a coincident timeout.
        if (rsp_take) begin
          data_done = 1'b1;
          state_n   = S_RESP;
        end else if (tmo_hit) begin
          tmo_fire = 1'b1;
          state_n  = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.wb_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Registered outputs and captured request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.req_ready     <= 1'b1;
      bus.mem_req_valid <= 1'b0;
      bus.mem_addr      <= '0;
      bus.wb_valid      <= 1'b0;
      bus.wb_data       <= '0;
      bus.wb_rd         <= '0;
      bus.wb_err        <= 1'b0;
      ctrl_q            <= '0;
    end else begin
      bus.req_ready     <= (state_n == S_IDLE);
      bus.mem_req_valid <= (state_n == S_REQ);
      bus.wb_valid      <= (state_n == S_RESP);
      if (accept) begin
        ctrl_q    <= ctrl_in;
        bus.wb_rd <= bus.req_rd;
        if (req_err) begin
          bus.wb_err  <= 1'b1;
          bus.wb_data <= '0;
        end else begin
          bus.mem_addr <= {bus.req_addr[XLEN-1:LANE_W], LANE_W'(0)};
        end
      end
      if (data_done) begin
        bus.wb_data <= ext_data_c;
        bus.wb_err  <= 1'b0;
      end
      if (tmo_fire) begin
        bus.wb_data <= '0;
        bus.wb_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: table of single loads plus backpressure,
// reset-in-WAIT and (with LOAD_TIMEOUT_EN) timeout sequences.
module tb_load_unit;
  import load_store_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  load_unit_if bus ();

`ifdef LOAD_TIMEOUT_EN
  load_unit #(.TIMEOUT_CYCLES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
  load_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " req_ready"},     32'(bus.req_ready), 32'd1);
    chk({tag, " mem_req_valid"}, 32'(bus.mem_req_valid), 32'd0);
    chk({tag, " mem_addr"},      bus.mem_addr, 32'd0);
    chk({tag, " wb_valid"},      32'(bus.wb_valid), 32'd0);
    chk({tag, " wb_data"},       bus.wb_data, 32'd0);
    chk({tag, " wb_rd"},         32'(bus.wb_rd), 32'd0);
    chk({tag, " wb_err"},        32'(bus.wb_err), 32'd0);
  endtask

  // One load from IDLE; called at a negedge, returns at a negedge back in IDLE.
  task automatic run_load(input vec_t v, input int mem_stall, input int wb_stall);
    logic [31:0] exp_maddr;
    exp_maddr = v.addr & 32'hFFFF_FFFC;
    chk("req_ready idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_rd     = v.rd;
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_addr   = 32'hFFFF_FFFF;
    bus.req_rd     = 5'd0;
    if (!v.exp_err) begin
      chk("mem_req_valid", 32'(bus.mem_req_valid), 32'd1);
      chk("mem_addr", bus.mem_addr, exp_maddr);
      chk("wb_valid early", 32'(bus.wb_valid), 32'd0);
      for (int i = 0; i < mem_stall; i++) begin
        @(negedge clk);
        chk("mem_addr hold", bus.mem_addr, exp_maddr);
        chk("mem_req_valid hold", 32'(bus.mem_req_valid), 32'd1);
        chk("req_ready busy", 32'(bus.req_ready), 32'd0);
      end
      bus.mem_req_ready = 1'b1;
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
      chk("mem_req_valid drop", 32'(bus.mem_req_valid), 32'd0);
      chk("wb_valid in wait", 32'(bus.wb_valid), 32'd0);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = v.rdata;
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'hDEAD_BEEF;
    end else begin
      chk("no mem req", 32'(bus.mem_req_valid), 32'd0);
    end
    chk("wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("wb_data", bus.wb_data, v.exp_data);
    chk("wb_err", 32'(bus.wb_err), 32'(v.exp_err));
    chk("wb_rd", 32'(bus.wb_rd), 32'(v.rd));
    if (wb_stall > 0) begin
      bus.wb_ready = 1'b0;
      for (int i = 0; i < wb_stall; i++) begin
        @(negedge clk);
        chk("wb_valid hold", 32'(bus.wb_valid), 32'd1);
        chk("wb_data hold", bus.wb_data, v.exp_data);
        chk("wb_rd hold", 32'(bus.wb_rd), 32'(v.rd));
        chk("req_ready wb stall", 32'(bus.req_ready), 32'd0);
      end
      bus.wb_ready = 1'b1;
    end
    @(negedge clk);
    chk("wb_valid retire", 32'(bus.wb_valid), 32'd0);
    chk("req_ready back", 32'(bus.req_ready), 32'd1);
  endtask

  vec_t vecs[14];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   n;

    vecs[0]  = '{F3_LB,  32'h0000_1003, 5'd5,  32'h80FF_1234, 32'hFFFF_FF80, 1'b0};
    vecs[1]  = '{F3_LHU, 32'h0000_2002, 5'd6,  32'hBEEF_0001, 32'h0000_BEEF, 1'b0};
    vecs[2]  = '{F3_LH,  32'h0000_2002, 5'd7,  32'hBEEF_0001, 32'hFFFF_BEEF, 1'b0};
    vecs[3]  = '{F3_LBU, 32'h0000_1001, 5'd8,  32'h1234_5678, 32'h0000_0056, 1'b0};
    vecs[4]  = '{F3_LB,  32'h0000_1000, 5'd9,  32'h0000_007F, 32'h0000_007F, 1'b0};
    vecs[5]  = '{F3_LH,  32'h0000_0000, 5'd10, 32'h0000_8001, 32'hFFFF_8001, 1'b0};
    vecs[6]  = '{F3_LW,  32'h0000_4000, 5'd11, 32'hCAFE_BABE, 32'hCAFE_BABE, 1'b0};
    vecs[7]  = '{F3_LBU, 32'h0000_1002, 5'd12, 32'h00AB_0000, 32'h0000_00AB, 1'b0};
    vecs[8]  = '{F3_LW,  32'h0000_3001, 5'd13, 32'h0,         32'h0,         1'b1};
    vecs[9]  = '{3'b011, 32'h0000_3000, 5'd14, 32'h0,         32'h0,         1'b1};
    vecs[10] = '{F3_LH,  32'h0000_5001, 5'd15, 32'h0,         32'h0,         1'b1};
    vecs[11] = '{F3_LHU, 32'h0000_5003, 5'd16, 32'h0,         32'h0,         1'b1};
    vecs[12] = '{3'b110, 32'h0000_6000, 5'd17, 32'h0,         32'h0,         1'b1};
    vecs[13] = '{F3_LW,  32'h0000_3002, 5'd18, 32'h0,         32'h0,         1'b1};

    rst_n             = 1'b0;
    bus.req_valid     = 1'b0;
    bus.req_funct3    = 3'd0;
    bus.req_addr      = 32'd0;
    bus.req_rd        = 5'd0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rvalid    = 1'b0;
    bus.mem_rdata     = 32'd0;
    bus.wb_ready      = 1'b1;

    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) run_load(vecs[i], 0, 0);

    // Backpressure on both the memory request and the writeback.
    v = '{F3_LB, 32'h0000_7003, 5'd21, 32'h7F00_0000, 32'h0000_007F, 1'b0};
    run_load(v, 3, 2);
    v = '{F3_LW, 32'h0000_7001, 5'd22, 32'h0, 32'h0, 1'b1};
    run_load(v, 0, 2);

    // Reset asserted while waiting for read data; the late response is ignored.
    bus.req_valid  = 1'b1;
    bus.req_funct3 = F3_LW;
    bus.req_addr   = 32'h0000_6000;
    bus.req_rd     = 5'd3;
    @(negedge clk);
    bus.req_valid     = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst in wait");
    @(negedge clk);
    rst_n          = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5555_AAAA;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("after late rvalid");

`ifdef LOAD_TIMEOUT_EN
    // No response: timeout after 4 WAIT cycles, then the stray response is dropped.
    bus.req_valid  = 1'b1;
    bus.req_funct3 = F3_LW;
    bus.req_addr   = 32'h0000_0100;
    bus.req_rd     = 5'd9;
    bus.wb_ready   = 1'b0;
    @(negedge clk);
    bus.req_valid     = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && !bus.wb_valid; i++) begin
      @(negedge clk);
      n++;
    end
    chk("tmo wait cycles", 32'(n), 32'd4);
    chk("tmo wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("tmo wb_err", 32'(bus.wb_err), 32'd1);
    chk("tmo wb_data", bus.wb_data, 32'd0);
    chk("tmo wb_rd", 32'(bus.wb_rd), 32'd9);
    bus.wb_ready = 1'b1;
    @(negedge clk);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1111_1111;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    chk("stale no wb", 32'(bus.wb_valid), 32'd0);
    v = '{F3_LW, 32'h0000_0200, 5'd10, 32'h2222_3333, 32'h2222_3333, 1'b0};
    run_load(v, 0, 0);
`else
    n = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
